// File: rtl/pipe_div_ex.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Optional two's-complement mode is enabled by defining DIV_SIGNED_EN.
module pipe_div_ex #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] F,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [N-1:0]  rem_q, dvd_q, dvs_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  q_q, r_q;
    logic          dbz_q;

    logic          accept, last, neg;
    logic [N:0]    shifted, trial;
    logic [N-1:0]  rem_next, quo_next;
    logic [N-1:0]  f_mag, d_mag, q_fin, r_fin;

`ifdef DIV_SIGNED_EN
    logic q_neg_q, r_neg_q;

    // Magnitudes feed the unsigned core; the most-negative value maps to 2^(N-1).
    always_comb begin
        f_mag = F[N-1] ? ('0 - F) : F;
        d_mag = D[N-1] ? ('0 - D) : D;
        q_fin = q_neg_q ? ('0 - quo_next) : quo_next;
        r_fin = r_neg_q ? ('0 - rem_next) : rem_next;
    end
`else
    always_comb begin
        f_mag = F;
        d_mag = D;
        q_fin = quo_next;
        r_fin = rem_next;
    end
`endif

    // Handshake: a request is taken on any edge where start=1 and the core is
    // not in RUN; F/D are sampled only on that edge.
    assign accept = start && (state != RUN);
    assign last   = (cnt_q == '0);

    // The shifted remainder is below 2*divisor, so bit N of the N+1-bit
    // trial difference is a reliable borrow flag.
    always_comb begin
        shifted  = {rem_q, dvd_q[N-1]};
        trial    = shifted - {1'b0, dvs_q};
        neg      = trial[N];
        rem_next = neg ? shifted[N-1:0] : trial[N-1:0];
        quo_next = {dvd_q[N-2:0], ~neg};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (D == '0) ? DONE : RUN;
            RUN:  if (last) state_next = DONE;
            DONE: begin
                if (start) state_next = (D == '0) ? DONE : RUN;
                else       state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                rem_q <= '0;
                dvd_q <= f_mag;
                dvs_q <= d_mag;
                cnt_q <= CW'(N - 1);
                dbz_q <= (D == '0);
`ifdef DIV_SIGNED_EN
                q_neg_q <= F[N-1] ^ D[N-1];
                r_neg_q <= F[N-1];
`endif
                // Divide-by-zero completes immediately with the raw dividend.
                if (D == '0) begin
                    q_q <= '1;
                    r_q <= F;
                end
            end else if (state == RUN) begin
                rem_q <= rem_next;
                dvd_q <= quo_next;
                cnt_q <= cnt_q - CW'(1);
                if (last) begin
                    q_q <= q_fin;
                    r_q <= r_fin;
                end
            end
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_pipe_div_ex.sv
// Directed bench for pipe_div_ex: reset, unsigned vectors, divide-by-zero,
// handshake/abort cases, and signed vectors when DIV_SIGNED_EN is defined.
module tb_pipe_div_ex;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] F, D;
    logic [N-1:0] Q, R;
    logic         busy, done, div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_div_ex #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .F(F), .D(D),
        .Q(Q), .R(R), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    // lat: edges after the accepting edge at which done is observed (N, or 0 for D=0).
    task automatic run_op(input string tag, input logic [N-1:0] f, input logic [N-1:0] d,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic edz, input int lat);
        int cnt;
        @(negedge clk);
        start = 1'b1; F = f; D = d;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_busy"}, busy, (d != 0));
        wait_done(cnt);
        check_eq({tag, "_lat"}, cnt, lat);
        check_eq({tag, "_q"}, Q, eq);
        check_eq({tag, "_r"}, R, er);
        check_eq({tag, "_dbz"}, div_by_zero, edz);
    endtask

    initial begin
        int cnt;
        bit seen;
        rst = 1'b1; start = 1'b0; F = '0; D = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_q", Q, 0);
        check_eq("rst_r", R, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_outs", {busy, done, div_by_zero, Q, R}, 0);

        run_op("basic",   10'd100,  10'd7,   10'd14,   10'd2, 1'b0, 10);
        run_op("max_by1", 10'd1023, 10'd1,   10'd1023, 10'd0, 1'b0, 10);
        run_op("f_lt_d",  10'd3,    10'd10,  10'd0,    10'd3, 1'b0, 10);
        run_op("f_eq_d",  10'd512,  10'd512, 10'd1,    10'd0, 1'b0, 10);
        run_op("dz",      10'd5,    10'd0,   10'd1023, 10'd5, 1'b1, 0);
        run_op("after_dz", 10'd9,   10'd3,   10'd3,    10'd0, 1'b0, 10);

        // start re-pulsed with new operands three edges into RUN is ignored
        @(negedge clk);
        start = 1'b1; F = 10'd200; D = 10'd9;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 40) begin
            if (cnt == 3) begin
                start = 1'b1; F = 10'd50; D = 10'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        check_eq("ign_lat", cnt, 10);
        check_eq("ign_q", Q, 22);
        check_eq("ign_r", R, 2);

        // reset five edges into RUN aborts without a done pulse
        @(negedge clk);
        start = 1'b1; F = 10'd100; D = 10'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_outs", {busy, done, div_by_zero, Q, R}, 0);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check_eq("abort_nodone", seen, 0);

        // start held high: second request accepted in the DONE cycle
        @(negedge clk);
        start = 1'b1; F = 10'd100; D = 10'd7;
        @(posedge clk); #1;
        wait_done(cnt);
        check_eq("b2b_lat1", cnt, 10);
        check_eq("b2b_q1", Q, 14);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!done && cnt < 40);
        start = 1'b0;
        check_eq("b2b_gap", cnt, 11);
        check_eq("b2b_q2", Q, 14);
        check_eq("b2b_r2", R, 2);
        @(posedge clk); #1;
        check_eq("b2b_idle", {busy, done}, 0);

`ifdef DIV_SIGNED_EN
        run_op("s_negf",  10'd924, 10'd7,    10'd1010, 10'd1022, 1'b0, 10);
        run_op("s_negd",  10'd100, 10'd1017, 10'd1010, 10'd2,    1'b0, 10);
        run_op("s_minm1", 10'd512, 10'd1023, 10'd512,  10'd0,    1'b0, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
